hero_bus_arb: RTL
=================

HERO_BUS_ARB -- requirements
Module: hero_bus_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the hero write bus.
REQ-002 Parameter HERO_WIDTH, default 36: write data width per beat.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per locked transaction.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_vld  input  NUM_REQ  per-requester beat valid.
REQ-008 req_cycle_type  input  NUM_REQ*2  per-requester beat type: IDLE=0, VALID=1, DONE=2, 3 illegal.
REQ-009 req_wdat  input  NUM_REQ*HERO_WIDTH  per-requester beat data.
REQ-010 req_rdy  output  NUM_REQ  per-requester beat accept.
REQ-011 hero_stall  input  1  downstream stall; no beat accepted, outputs hold.
REQ-012 hero_cycle_type  output  2  registered bus cycle type.
REQ-013 hero_wdat  output  HERO_WIDTH  registered bus data.
REQ-014 hero_clk_en  output  1  high when hero_cycle_type is VALID or DONE.
REQ-015 hero_owner  output  clog2(NUM_REQ)  index of requester that drove current output beat.
REQ-016 err_protocol  output  1  one-cycle pulse on protocol violation.

Function
REQ-017 Beat transfer from requester i SHALL occur when req_vld[i] and req_rdy[i] are both high.
REQ-018 At most one req_rdy bit SHALL be high per cycle; all req_rdy SHALL be low while hero_stall is high.
REQ-019 FSM states: ARB and LOCK.
REQ-020 ARB: rr pointer selects first requester with req_vld set, searching from (last_owner+1) mod NUM_REQ upward with wrap; req_rdy of the selected requester is driven high in the same cycle (combinational grant).
REQ-021 ARB, accepted VALID beat: latch owner, beat count = 1, go to LOCK.
REQ-022 ARB, accepted DONE beat: single-beat transaction, stay in ARB, last_owner = selected.
REQ-023 LOCK: only the owner may receive req_rdy; other requesters wait regardless of req_vld.
REQ-024 LOCK, accepted VALID beat: increment beat count.
REQ-025 LOCK, accepted DONE beat: last_owner = owner, go to ARB; arbitration for the next transaction starts the following cycle.
REQ-026 LOCK, owner req_vld low: stay in LOCK; output is an IDLE cycle (hero_clk_en=0); no timeout on idle gaps.
REQ-027 An accepted VALID beat that makes beat count equal MAX_BURST SHALL be forwarded as DONE; err_protocol pulses; FSM returns to ARB.
REQ-028 An accepted beat with type IDLE or 3 SHALL be consumed, not forwarded, and pulses err_protocol; state and beat count are unchanged.
REQ-029 Output registers update only when hero_stall is low: accepted legal beat -> type/data/owner of that beat; otherwise hero_cycle_type=IDLE, hero_wdat=0, hero_owner holds.
REQ-030 Latency: accepted beat SHALL appear on hero_* exactly one cycle after acceptance (stall-free).
REQ-031 While hero_stall is high, the FSM, rr pointer, beat count and all outputs SHALL hold; err_protocol=0.
REQ-032 Beat count width SHALL be clog2(MAX_BURST+1); no wrap is possible because of REQ-027.

Reset
REQ-033 rst_n low SHALL immediately force: FSM=ARB, last_owner=NUM_REQ-1 (first search starts at 0), beat count=0, hero_cycle_type=IDLE, hero_wdat=0, hero_clk_en=0, hero_owner=0, err_protocol=0.
REQ-034 req_rdy SHALL be all-zero while rst_n is low.
REQ-035 Reset asserted mid-LOCK SHALL abandon the transaction with no DONE emitted; first grant after release goes to lowest-index valid requester.

Verification
REQ-036 After reset, req 0 and req 2 both present DONE beats every cycle -> grants alternate 0,2,0,2; hero_owner follows one cycle later.
REQ-037 Req 1 sends VALID,VALID,DONE (wdat 0x1,0x2,0x3) while req 3 is valid throughout -> req 3 is not granted until the cycle after the DONE from req 1 is accepted; bus shows 1,2,3 with clk_en=1.
REQ-038 MAX_BURST=4, req 0 streams VALID for 6 beats -> 4th beat is output as DONE, err_protocol pulses once, req 0 re-arbitrates normally.
REQ-039 hero_stall high for 3 cycles mid-burst -> req_rdy all 0, hero_* frozen 3 cycles, no beat lost or duplicated.
REQ-040 Req 2 owner presents cycle type 3 mid-LOCK -> beat consumed, err_protocol=1 for one cycle, output IDLE, lock retained.
REQ-041 rst_n asserted during LOCK of req 1 -> outputs zero immediately, req_rdy=0; after release req 0 (valid) granted first.

Source files
------------

// File: rtl/hero_bus_arb.sv
// rtl/hero_bus_arb.sv - round-robin arbiter with burst lock onto the shared hero write bus
module hero_bus_arb #(
    parameter int NUM_REQ    = 4,
    parameter int HERO_WIDTH = 36,
    parameter int MAX_BURST  = 16,
    localparam int OWN_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*2-1:0]          req_cycle_type,
    input  logic [NUM_REQ*HERO_WIDTH-1:0] req_wdat,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic                          hero_stall,
    output logic [1:0]                    hero_cycle_type,
    output logic [HERO_WIDTH-1:0]         hero_wdat,
    output logic                          hero_clk_en,
    output logic [OWN_W-1:0]              hero_owner,
    output logic                          err_protocol
);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    localparam logic [1:0] CT_IDLE  = 2'd0;
    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;

    state_t                  state_q, state_d;
    logic [OWN_W-1:0]        last_q, last_d;
    logic [OWN_W-1:0]        own_q, own_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              ty_d;
    logic [HERO_WIDTH-1:0]   wd_d;
    logic [OWN_W-1:0]        owner_d;

    logic [1:0]              ty_a  [NUM_REQ];
    logic [HERO_WIDTH-1:0]   dat_a [NUM_REQ];
    logic [OWN_W-1:0]        sel, cand;
    logic                    found, accept, legal, cap, ends_txn;
    logic [1:0]              beat_ty;
    logic [CNT_W-1:0]        cnt_inc;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign ty_a[i]  = req_cycle_type[2*i +: 2];
        assign dat_a[i] = req_wdat[i*HERO_WIDTH +: HERO_WIDTH];
    end

    // Locked: only the owner is eligible. Arbitrating: first valid after last_owner, wrapping.
    always_comb begin
        cand  = '0;
        sel   = '0;
        found = 1'b0;
        if (state_q == ST_LOCK) begin
            sel   = own_q;
            found = req_vld[own_q];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = OWN_W'((int'(last_q) + k) % NUM_REQ);
                if (!found && req_vld[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    assign accept   = rst_n && !hero_stall && found;
    assign beat_ty  = ty_a[sel];
    assign legal    = (beat_ty == CT_VALID) || (beat_ty == CT_DONE);
    assign cnt_inc  = (state_q == ST_ARB) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign cap      = (beat_ty == CT_VALID) && (cnt_inc == CNT_W'(MAX_BURST));
    assign ends_txn = (beat_ty == CT_DONE) || cap;

    always_comb begin
        req_rdy = '0;
        if (accept) begin
            req_rdy[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        own_d        = own_q;
        cnt_d        = cnt_q;
        ty_d         = hero_cycle_type;
        wd_d         = hero_wdat;
        owner_d      = hero_owner;
        err_protocol = 1'b0;
        if (!hero_stall) begin
            ty_d = CT_IDLE;
            wd_d = '0;
            if (accept) begin
                if (!legal) begin
                    // illegal beat is swallowed; lock and count stay as they were
                    err_protocol = 1'b1;
                end else begin
                    wd_d    = dat_a[sel];
                    owner_d = sel;
                    if (ends_txn) begin
                        ty_d         = CT_DONE;
                        err_protocol = cap;
                        state_d      = ST_ARB;
                        last_d       = sel;
                        cnt_d        = '0;
                    end else begin
                        ty_d    = CT_VALID;
                        state_d = ST_LOCK;
                        own_d   = sel;
                        cnt_d   = cnt_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_ARB;
            last_q          <= OWN_W'(NUM_REQ - 1);
            own_q           <= '0;
            cnt_q           <= '0;
            hero_cycle_type <= CT_IDLE;
            hero_wdat       <= '0;
            hero_owner      <= '0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            own_q           <= own_d;
            cnt_q           <= cnt_d;
            hero_cycle_type <= ty_d;
            hero_wdat       <= wd_d;
            hero_owner      <= owner_d;
        end
    end

    assign hero_clk_en = (hero_cycle_type == CT_VALID) || (hero_cycle_type == CT_DONE);

endmodule
